muldiv_alu_seq: RTL

Iterative multiply/divide sequencer for the MIPS32 pipeline. It executes MULT/MULTU/DIV/DIVU by borrowing the shared 32-bit combinational ALU one operation per cycle, and it arbitrates that ALU against the EX stage. Results land in HI/LO registers owned by this block. It sits beside EX; a top-level mux selects the ALU operands from this block whenever `seq_grant` is high.

---
 rtl/muldiv_alu_seq.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_alu_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer that borrows the shared EX-stage ALU; results in HI/LO.
// Optional starvation guard enabled by defining MULDIV_STARVE_GUARD_EN.
module muldiv_alu_seq #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        ex_alu_req,
    input  logic [31:0] alu_res,
    output logic [3:0]  seq_aluCON,
    output logic [31:0] seq_In1,
    output logic [31:0] seq_In2,
    output logic        seq_grant,
    output logic        ex_stall,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam logic [3:0] AluAddu = 4'hE;
    localparam logic [3:0] AluSubu = 4'hF;
    localparam logic [3:0] AluXor  = 4'h4;

    typedef enum logic [2:0] {StIdle, StNegA, StNegB, StIter, StFixLo, StFixHi, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic        neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
    logic        lo_zero_q, lo_zero_d, div_zero_q, div_zero_d;
    logic        need, advance, is_div, is_signed, start_dz, carry, borrow;
    logic [31:0] rprime;

    assign is_div    = op_q[1];
    assign is_signed = ~op_q[0];
    assign start_dz  = op[1] & (rt_val == '0);
    assign rprime    = {hi_q[30:0], lo_q[31]};
    assign carry     = (hi_q[31] & a_q[31]) | ((hi_q[31] | a_q[31]) & ~alu_res[31]);
    assign borrow    = (~rprime[31] & b_q[31]) | ((~rprime[31] | b_q[31]) & alu_res[31]);
    assign advance   = ~need | seq_grant;

`ifdef MULDIV_STARVE_GUARD_EN
    logic [31:0] starve_q, starve_d;
    logic        force_grant;

    // After STARVE_LIMIT consecutive stalls the next needing cycle takes the ALU from EX.
    assign force_grant = need & (starve_q >= STARVE_LIMIT);
    assign seq_grant   = need & (~ex_alu_req | force_grant);
    assign ex_stall    = force_grant;

    always_comb begin
        starve_d = starve_q;
        if (seq_grant) begin
            starve_d = '0;
        end else if (need) begin
            starve_d = starve_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    logic unused_starve_limit;
    assign unused_starve_limit = ^STARVE_LIMIT;
    assign seq_grant = need & ~ex_alu_req;
    assign ex_stall  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            a_q        <= '0;
            b_q        <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            cnt_q      <= '0;
            op_q       <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            lo_zero_q  <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            lo_zero_q  <= lo_zero_d;
            div_zero_q <= div_zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = start_dz ? StDone : StNegA;
            StNegA:  if (advance) state_d = StNegB;
            StNegB:  if (advance) state_d = StIter;
            StIter:  if (advance && cnt_q == 5'd31) state_d = StFixLo;
            StFixLo: if (advance) state_d = StFixHi;
            StFixHi: if (advance) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        need       = 1'b0;
        seq_aluCON = AluSubu;
        seq_In1    = '0;
        seq_In2    = '0;
        case (state_q)
            StNegA: begin
                need    = is_signed & a_q[31];
                seq_In2 = a_q;
            end
            StNegB: begin
                need    = is_signed & b_q[31];
                seq_In2 = b_q;
            end
            StIter: begin
                need = is_div | lo_q[0];
                if (is_div) begin
                    seq_In1 = rprime;
                    seq_In2 = b_q;
                end else begin
                    seq_aluCON = AluAddu;
                    seq_In1    = hi_q;
                    seq_In2    = a_q;
                end
            end
            StFixLo: begin
                need    = neg_res_q;
                seq_In2 = lo_q;
            end
            StFixHi: begin
                need = is_signed & (is_div ? neg_rem_q : neg_res_q);
                // Low half nonzero means no borrow propagates into HI: a plain complement suffices.
                if (!is_div && !lo_zero_q) begin
                    seq_aluCON = AluXor;
                    seq_In1    = hi_q;
                    seq_In2    = '1;
                end else begin
                    seq_In2 = hi_q;
                end
            end
            default: need = 1'b0;
        endcase
        if (!need) begin
            seq_aluCON = '0;
            seq_In1    = '0;
            seq_In2    = '0;
        end
    end

    always_comb begin
        a_d        = a_q;
        b_d        = b_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        lo_zero_d  = lo_zero_q;
        div_zero_d = div_zero_q;
        case (state_q)
            StIdle: if (start) begin
                op_d       = op;
                a_d        = rs_val;
                b_d        = rt_val;
                div_zero_d = start_dz;
                neg_res_d  = ~op[0] & (rs_val[31] ^ rt_val[31]);
                neg_rem_d  = ~op[0] & op[1] & rs_val[31];
                if (start_dz) begin
                    hi_d = rs_val;
                    lo_d = '1;
                end
            end
            StNegA: if (need && seq_grant) a_d = alu_res;
            StNegB: if (advance) begin
                b_d   = need ? alu_res : b_q;
                hi_d  = '0;
                lo_d  = is_div ? a_q : b_d;
                cnt_d = '0;
            end
            StIter: if (advance) begin
                cnt_d = cnt_q + 5'd1;
                if (is_div) begin
                    if (hi_q[31] | ~borrow) begin
                        hi_d = alu_res;
                        lo_d = {lo_q[30:0], 1'b1};
                    end else begin
                        hi_d = rprime;
                        lo_d = {lo_q[30:0], 1'b0};
                    end
                end else if (lo_q[0]) begin
                    hi_d = {carry, alu_res[31:1]};
                    lo_d = {alu_res[0], lo_q[31:1]};
                end else begin
                    hi_d = {1'b0, hi_q[31:1]};
                    lo_d = {hi_q[0], lo_q[31:1]};
                end
            end
            StFixLo: if (advance) begin
                lo_zero_d = (lo_q == '0);
                if (need) lo_d = alu_res;
            end
            StFixHi: if (need && seq_grant) hi_d = alu_res;
            default: ;
        endcase
    end

    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
endmodule
